// File: rtl/cache_control_pkg.sv
// Shared types for the L1 cache controller: FSM state encoding and address mux selects.
package cache_control_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } lc3b_cache_state;

  typedef logic [1:0] lc3b_addrmux_sel;

  localparam lc3b_addrmux_sel ADDR_CPU  = 2'b00;
  localparam lc3b_addrmux_sel ADDR_WAY0 = 2'b01;
  localparam lc3b_addrmux_sel ADDR_WAY1 = 2'b10;

  // Writeback address select for the given victim way.
  function automatic lc3b_addrmux_sel way_addr(input logic way);
    return way ? ADDR_WAY1 : ADDR_WAY0;
  endfunction

endpackage

// File: rtl/cache_control_sat_counter.sv
// Saturating event counter; a synchronous clear takes priority over increment.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/cache_control.sv
// Control FSM for the 2-way write-back, write-allocate L1 cache with perf counters.
module cache_control
  import cache_control_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 mem_read,
  input  logic                 mem_write,
  output logic                 mem_resp,
  output logic                 pmem_read,
  output logic                 pmem_write,
  input  logic                 pmem_resp,
  input  logic                 ishit0_out,
  input  logic                 ishit1_out,
  input  logic                 dirtyarr0_out,
  input  logic                 dirtyarr1_out,
  input  logic                 lru_out,
  output logic                 dataarr0_write,
  output logic                 dataarr1_write,
  output logic                 tag0_write,
  output logic                 tag1_write,
  output logic                 valid0_write,
  output logic                 valid1_write,
  output logic                 dirtyarr0_write,
  output logic                 dirtyarr1_write,
  output logic                 dirty_in,
  output logic                 datainmux_sel,
  output lc3b_addrmux_sel      addressmux_sel,
  input  logic                 cnt_clear,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count,
  output logic [CNT_WIDTH-1:0] wb_count,
  output lc3b_cache_state      state_o
);

  lc3b_cache_state state_q, state_d;
  logic victim_q, victim_d;
  logic refill_q, refill_d;
  logic hit_inc, miss_inc, wb_inc;

  logic req, hit, hit_way, victim_dirty;
  assign req          = mem_read | mem_write;
  assign hit          = ishit0_out | ishit1_out;
  assign hit_way      = ~ishit0_out;  // way0 wins if both tags match
  assign victim_dirty = lru_out ? dirtyarr1_out : dirtyarr0_out;

  always_comb begin
    state_d         = state_q;
    victim_d        = victim_q;
    refill_d        = refill_q;
    hit_inc         = 1'b0;
    miss_inc        = 1'b0;
    wb_inc          = 1'b0;
    mem_resp        = 1'b0;
    pmem_read       = 1'b0;
    pmem_write      = 1'b0;
    dataarr0_write  = 1'b0;
    dataarr1_write  = 1'b0;
    tag0_write      = 1'b0;
    tag1_write      = 1'b0;
    valid0_write    = 1'b0;
    valid1_write    = 1'b0;
    dirtyarr0_write = 1'b0;
    dirtyarr1_write = 1'b0;
    dirty_in        = 1'b0;
    datainmux_sel   = 1'b0;
    addressmux_sel  = ADDR_CPU;
    unique case (state_q)
      IDLE: begin
        refill_d = 1'b0;
        if (req && hit) begin
          mem_resp = 1'b1;
          // The hit that completes a fill was already counted as a miss.
          hit_inc  = ~refill_q;
          if (mem_write) begin
            datainmux_sel   = 1'b1;
            dirty_in        = 1'b1;
            dataarr0_write  = ~hit_way;
            dataarr1_write  = hit_way;
            dirtyarr0_write = ~hit_way;
            dirtyarr1_write = hit_way;
          end
        end else if (req) begin
          miss_inc = 1'b1;
          victim_d = lru_out;
          state_d  = victim_dirty ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        pmem_write     = 1'b1;
        addressmux_sel = way_addr(victim_q);
        if (pmem_resp) begin
          wb_inc  = 1'b1;
          state_d = ALLOCATE;
        end
      end
      ALLOCATE: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          dataarr0_write  = ~victim_q;
          dataarr1_write  = victim_q;
          tag0_write      = ~victim_q;
          tag1_write      = victim_q;
          valid0_write    = ~victim_q;
          valid1_write    = victim_q;
          dirtyarr0_write = ~victim_q;
          dirtyarr1_write = victim_q;
          refill_d        = 1'b1;
          state_d         = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      victim_q <= 1'b0;
      refill_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
      refill_q <= refill_d;
    end
  end

  assign state_o = state_q;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_cnt (
    .clk_i(clk), .reset_n_i(reset_n), .clr_i(cnt_clear), .inc_i(hit_inc), .count_o(hit_count)
  );
  sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
    .clk_i(clk), .reset_n_i(reset_n), .clr_i(cnt_clear), .inc_i(miss_inc), .count_o(miss_count)
  );
  sat_counter #(.WIDTH(CNT_WIDTH)) u_wb_cnt (
    .clk_i(clk), .reset_n_i(reset_n), .clr_i(cnt_clear), .inc_i(wb_inc), .count_o(wb_count)
  );

endmodule

// File: tb/tb_cache_control.sv
// Directed bench for cache_control: scoreboard of expected output vectors on response/array-write cycles.
module tb_cache_control;
  import cache_control_pkg::*;

  localparam int CW = 8;
  localparam int W  = 15;

  // Output vector layout: resp, pread, pwrite, d0, d1, t0, t1, v0, v1, dy0, dy1, din, dmux, am[1:0]
  localparam logic [W-1:0] E_RESP  = 15'h4000;
  localparam logic [W-1:0] E_PREAD = 15'h2000;
  localparam logic [W-1:0] E_D0    = 15'h0800;
  localparam logic [W-1:0] E_D1    = 15'h0400;
  localparam logic [W-1:0] E_T0    = 15'h0200;
  localparam logic [W-1:0] E_T1    = 15'h0100;
  localparam logic [W-1:0] E_V0    = 15'h0080;
  localparam logic [W-1:0] E_V1    = 15'h0040;
  localparam logic [W-1:0] E_DY0   = 15'h0020;
  localparam logic [W-1:0] E_DY1   = 15'h0010;
  localparam logic [W-1:0] E_DIN   = 15'h0008;
  localparam logic [W-1:0] E_DMUX  = 15'h0004;

  logic clk, reset_n;
  logic mem_read, mem_write, mem_resp, pmem_read, pmem_write, pmem_resp;
  logic ishit0_out, ishit1_out, dirtyarr0_out, dirtyarr1_out, lru_out;
  logic dataarr0_write, dataarr1_write, tag0_write, tag1_write, valid0_write, valid1_write;
  logic dirtyarr0_write, dirtyarr1_write, dirty_in, datainmux_sel, cnt_clear;
  lc3b_addrmux_sel addressmux_sel;
  logic [CW-1:0] hit_count, miss_count, wb_count;
  lc3b_cache_state state_o;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  cache_control #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .reset_n(reset_n), .mem_read(mem_read), .mem_write(mem_write),
    .mem_resp(mem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp),
    .ishit0_out(ishit0_out), .ishit1_out(ishit1_out), .dirtyarr0_out(dirtyarr0_out),
    .dirtyarr1_out(dirtyarr1_out), .lru_out(lru_out),
    .dataarr0_write(dataarr0_write), .dataarr1_write(dataarr1_write),
    .tag0_write(tag0_write), .tag1_write(tag1_write),
    .valid0_write(valid0_write), .valid1_write(valid1_write),
    .dirtyarr0_write(dirtyarr0_write), .dirtyarr1_write(dirtyarr1_write),
    .dirty_in(dirty_in), .datainmux_sel(datainmux_sel), .addressmux_sel(addressmux_sel),
    .cnt_clear(cnt_clear), .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count),
    .state_o(state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] obs();
    return {mem_resp, pmem_read, pmem_write, dataarr0_write, dataarr1_write, tag0_write,
            tag1_write, valid0_write, valid1_write, dirtyarr0_write, dirtyarr1_write,
            dirty_in, datainmux_sel, addressmux_sel};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // monitor: any response or array write must match the next expected vector
  always @(negedge clk) begin
    if (reset_n && (mem_resp || dataarr0_write || dataarr1_write || tag0_write || tag1_write ||
                    dirtyarr0_write || dirtyarr1_write)) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event: got 0x%0h expected no event", obs());
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (obs() !== e) begin
          failures++;
          $display("FAIL event_vector: got 0x%0h expected 0x%0h", obs(), e);
        end
      end
    end
  end

  // driver tasks
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_read = 0; mem_write = 0; pmem_resp = 0; ishit0_out = 0; ishit1_out = 0;
    dirtyarr0_out = 0; dirtyarr1_out = 0; lru_out = 0; cnt_clear = 0;
  endtask

  task automatic clear_counters();
    cnt_clear = 1;
    cycle();
    cnt_clear = 0;
    check("clear_hit", 32'(hit_count), 0);
    check("clear_miss", 32'(miss_count), 0);
    check("clear_wb", 32'(wb_count), 0);
  endtask

  initial begin
    idle_inputs();
    reset_n = 0;
    #3;
    check("reset_outputs", 32'(obs()), 0);
    check("reset_state", 32'(state_o), 32'(IDLE));
    check("reset_counts", {8'd0, hit_count, miss_count, wb_count}, 0);
    #9 reset_n = 1;

    // read hit in way1
    cycle();
    mem_read = 1; ishit1_out = 1;
    exp_q.push_back(E_RESP);
    cycle();
    idle_inputs();
    check("rd_hit_count", 32'(hit_count), 1);

    // write hit in way0
    mem_write = 1; ishit0_out = 1;
    exp_q.push_back(E_RESP | E_D0 | E_DY0 | E_DIN | E_DMUX);
    cycle();
    idle_inputs();
    check("wr_hit_count", 32'(hit_count), 2);

    // clean read miss, victim way1; lru flips mid-fill to prove victim is latched
    clear_counters();
    mem_read = 1; lru_out = 1; dirtyarr1_out = 0;
    cycle();
    check("miss_state", 32'(state_o), 32'(ALLOCATE));
    lru_out = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        pmem_resp = 1;
        exp_q.push_back(E_PREAD | E_D1 | E_T1 | E_V1 | E_DY1);
      end
      @(negedge clk);
      check("alloc_pread", {30'd0, pmem_read, pmem_write}, 32'd2);
      check("alloc_addrmux", 32'(addressmux_sel), 32'(ADDR_CPU));
      cycle();
    end
    pmem_resp = 0; ishit1_out = 1;
    check("pread_drop", 32'(pmem_read), 0);
    exp_q.push_back(E_RESP);
    cycle();
    idle_inputs();
    check("clean_miss_count", 32'(miss_count), 1);
    check("clean_hit_count", 32'(hit_count), 0);

    // dirty write miss, victim way0
    mem_write = 1; lru_out = 0; dirtyarr0_out = 1;
    cycle();
    check("wb_state", 32'(state_o), 32'(WRITEBACK));
    lru_out = 1; dirtyarr0_out = 0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) pmem_resp = 1;
      @(negedge clk);
      check("wb_pwrite", {30'd0, pmem_read, pmem_write}, 32'd1);
      check("wb_addrmux", 32'(addressmux_sel), 32'(ADDR_WAY0));
      cycle();
    end
    pmem_resp = 0;
    check("wb_to_alloc", 32'(state_o), 32'(ALLOCATE));
    cycle();
    pmem_resp = 1;
    exp_q.push_back(E_PREAD | E_D0 | E_T0 | E_V0 | E_DY0);
    cycle();
    pmem_resp = 0; ishit0_out = 1;
    exp_q.push_back(E_RESP | E_D0 | E_DY0 | E_DIN | E_DMUX);
    cycle();
    idle_inputs();
    check("dirty_wb_count", 32'(wb_count), 1);
    check("dirty_miss_count", 32'(miss_count), 2);
    check("dirty_hit_count", 32'(hit_count), 0);

    // stray pmem_resp in IDLE
    pmem_resp = 1;
    cycle();
    pmem_resp = 0;
    check("stray_resp_state", 32'(state_o), 32'(IDLE));
    check("stray_resp_pmem", {30'd0, pmem_read, pmem_write}, 0);

    // both hits plus read+write: write to way0
    mem_read = 1; mem_write = 1; ishit0_out = 1; ishit1_out = 1;
    exp_q.push_back(E_RESP | E_D0 | E_DY0 | E_DIN | E_DMUX);
    cycle();
    idle_inputs();
    check("dual_hit_count", 32'(hit_count), 1);

    // reset pulsed during ALLOCATE
    mem_read = 1; lru_out = 1;
    cycle();
    check("pre_reset_pread", 32'(pmem_read), 1);
    #2 reset_n = 0;
    #1;
    check("reset_pread", 32'(pmem_read), 0);
    check("reset_mid_state", 32'(state_o), 32'(IDLE));
    check("reset_mid_counts", {8'd0, hit_count, miss_count, wb_count}, 0);
    idle_inputs();
    cycle();
    reset_n = 1;

    // saturation and clear priority
    mem_read = 1; ishit0_out = 1;
    for (int i = 0; i < (1 << CW); i++) begin
      exp_q.push_back(E_RESP);
      cycle();
    end
    check("sat_hit_count", 32'(hit_count), 32'((1 << CW) - 1));
    cnt_clear = 1;
    exp_q.push_back(E_RESP);
    cycle();
    idle_inputs();
    check("clr_over_inc", 32'(hit_count), 0);

    cycle();
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
